// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : PC/nPC fetch sequencer with delayed-branch redirect, pending
//               redirect capture across stalls, and accepted-fetch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_annul,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr,
    output logic [31:0] npc_out,
    output logic        slot_annul,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] c_BOOT = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    localparam logic [31:0] c_PC_RESET  = 32'h0000_0000;
    localparam logic [31:0] c_NPC_RESET = 32'h0000_0004;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic        r_pend_annul;
    logic        r_slot_annul;
    logic [15:0] r_fetch_count;

    logic        w_fetch_valid;
    logic        w_advance;
    logic        w_redirect;
    logic [31:0] w_br_target_aligned;
    logic [31:0] w_redir_target;
    logic        w_redir_annul;

    assign w_fetch_valid       = (r_state != c_BOOT);
    assign w_advance           = w_fetch_valid & fetch_ready & ~stall;
    assign w_br_target_aligned = br_target & ~32'h0000_0003;

    // A live branch outranks one captured during an earlier stall.
    assign w_redirect     = br_taken | r_pend_valid;
    assign w_redir_target = br_taken ? w_br_target_aligned : r_pend_target;
    assign w_redir_annul  = br_taken ? br_annul : r_pend_annul;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_BOOT:  w_state_nxt = c_RUN;
            c_RUN:   w_state_nxt = w_advance ? c_RUN : c_WAIT;
            c_WAIT:  w_state_nxt = w_advance ? c_RUN : c_WAIT;
            default: w_state_nxt = c_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_BOOT;
            r_pc          <= c_PC_RESET;
            r_npc         <= c_NPC_RESET;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0000_0000;
            r_pend_annul  <= 1'b0;
            r_slot_annul  <= 1'b0;
            r_fetch_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_advance) begin
                r_pc          <= r_npc;
                r_npc         <= w_redirect ? w_redir_target : (r_npc + 32'd4);
                r_slot_annul  <= w_redirect & w_redir_annul;
                r_pend_valid  <= 1'b0;
                r_fetch_count <= r_fetch_count + 16'd1;
            end else if (br_taken) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_br_target_aligned;
                r_pend_annul  <= br_annul;
            end
        end
    end

    assign fetch_valid = w_fetch_valid;
    assign fetch_addr  = r_pc;
    assign npc_out     = r_npc;
    assign slot_annul  = r_slot_annul;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Ports SHALL be, one clock domain; reset is synchronous and active-high:
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising clk edge.
REQ-004 stall  in  1  pipeline hold; 1 = PC/nPC SHALL NOT advance.
REQ-005 br_taken  in  1  branch/jump redirect request, single-cycle pulse from decode.
REQ-006 br_target  in  32  redirect target address.
REQ-007 br_annul  in  1  qualifies br_taken; 1 = delay-slot instruction is annulled.
REQ-008 fetch_ready  in  1  instruction memory accepts fetch_addr this cycle.
REQ-009 fetch_valid  out  1  fetch_addr is a valid request.
REQ-010 fetch_addr  out  32  current PC presented to instruction memory.
REQ-011 npc_out  out  32  next PC.
REQ-012 slot_annul  out  1  the instruction at fetch_addr is an annulled delay slot.
REQ-013 fetch_count  out  16  number of accepted fetches, wraps modulo 2^16.

Function
REQ-014 State SHALL be PC, nPC, pend_valid, pend_target, pend_annul, slot_annul, fetch_count, and a 3-state FSM: BOOT, RUN, WAIT.
REQ-015 A fetch SHALL be accepted ("advance") in a cycle where fetch_valid=1, fetch_ready=1 and stall=0.
REQ-016 On advance: PC <= nPC; nPC <= redirect target if a redirect applies, else nPC+4; fetch_count <= fetch_count+1.
REQ-017 A redirect SHALL apply on advance if br_taken=1 that cycle or pend_valid=1; a live br_taken has priority over the pending one.
REQ-018 nPC+4 SHALL be computed modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-019 br_target bits [1:0] SHALL be forced to 0 when loaded into nPC or pend_target.
REQ-020 br_taken in a non-advance cycle SHALL set pend_valid=1 and capture target/annul; a later br_taken before the advance SHALL overwrite them.
REQ-021 pend_valid SHALL clear on the advance that consumes it.
REQ-022 slot_annul SHALL be set on an advance whose applied redirect has annul=1, cleared on any other advance, and held otherwise.
REQ-023 When not advancing, PC, nPC, fetch_addr and slot_annul SHALL hold stable.
REQ-024 BOOT: fetch_valid=0; always go to RUN next cycle.
REQ-025 RUN: fetch_valid=1; fetch_ready=0 or stall=1 -> WAIT; advance -> RUN.
REQ-026 WAIT: fetch_valid=1, address held; advance -> RUN, else stay WAIT.
REQ-027 fetch_addr SHALL equal PC; npc_out SHALL equal nPC (no added latency).
REQ-028 br_taken in BOOT SHALL be captured as pending.

Reset
REQ-029 reset=1 at a clock edge SHALL force PC=0x00000000, nPC=0x00000004, pend_valid=0, slot_annul=0, fetch_count=0, FSM=BOOT, overriding any simultaneous advance or br_taken.
REQ-030 Reset asserted mid-WAIT SHALL abandon the outstanding request; fetch_valid=0 on the following cycle.

Verification
REQ-031 Reset then fetch_ready=1 steady -> BOOT 1 cycle, then fetch_addr 0,4,8,12 on consecutive cycles; fetch_count 1,2,3.
REQ-032 At PC=8,nPC=12, br_taken=1, target=0x100, annul=0, advance -> fetch_addr 12 (slot) then 0x100; slot_annul=0.
REQ-033 Same with annul=1, target=0x103 -> slot at 12 has slot_annul=1; next fetch_addr 0x100, slot_annul=0.
REQ-034 fetch_ready=0 for 3 cycles while br_taken pulses to 0x200 then 0x300 -> address held; after ready, nPC=0x300.
REQ-035 PC=0xFFFFFFF8,nPC=0xFFFFFFFC, no branch -> fetch_addr sequence 0xFFFFFFFC, 0x00000000.
REQ-036 reset asserted in WAIT with pend_valid=1 -> next cycle fetch_valid=0, pend_valid=0, nPC=4.
